muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 173 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Sequential radix-2 multiply/divide unit with architectural HI/LO registers.
// One step per cycle: 32 RUN cycles, then a single DONE cycle that presents and commits the result.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        we_hi,
    input  logic        we_lo,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        res_valid,
    output logic [63:0] res,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_mag_q, a_mag_d;
    logic [31:0] b_mag_q, b_mag_d;
    logic        sa_q, sa_d, sb_q, sb_d;
    logic        dz_q, dz_d;
    logic [31:0] rem_q, rem_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        in_signed;
    logic [31:0] in_a_mag, in_b_mag;
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] rem_sub;
    logic [32:0] mul_sum;
    logic        neg;
    logic [31:0] quo_fix, rem_fix;
    logic [63:0] result;

    // Operand magnitudes; -0x80000000 wraps to 0x80000000, which is 2^31 read unsigned.
    assign in_signed = ~op[0];
    assign in_a_mag  = (in_signed && a[31]) ? -a : a;
    assign in_b_mag  = (in_signed && b[31]) ? -b : b;

    // Divide step: acc_q[31:0] shifts the dividend out while the quotient bits shift in.
    assign rem_shift = {rem_q, acc_q[31]};
    assign rem_ge    = rem_shift >= {1'b0, b_mag_q};
    assign rem_sub   = rem_shift[31:0] - b_mag_q;

    // Multiply step: multiplier sits in acc_q[31:0] and is consumed LSB first.
    assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_mag_q} : 33'd0);

    assign neg     = sa_q ^ sb_q;
    assign quo_fix = neg  ? -acc_q[31:0] : acc_q[31:0];
    assign rem_fix = sa_q ? -rem_q       : rem_q;

    always_comb begin
        if (dz_q)
            result = acc_q;
        else if (op_q[1])
            result = {rem_fix, quo_fix};
        else
            result = neg ? -acc_q : acc_q;
    end

    always_comb begin
        // NOTE: every next-state value gets a hold default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_mag_d = a_mag_q;
        b_mag_d = b_mag_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (state_q != DONE) begin
            if (we_hi) hi_d = wdata;
            if (we_lo) lo_d = wdata;
        end

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d    = op;
                    a_mag_d = in_a_mag;
                    b_mag_d = in_b_mag;
                    sa_d    = in_signed & a[31];
                    sb_d    = in_signed & b[31];
                    cnt_d   = 5'd0;
                    rem_d   = 32'd0;
                    if (op[1] && (b == 32'd0)) begin
                        dz_d    = 1'b1;
                        acc_d   = {a, 32'hFFFF_FFFF};
                        state_d = DONE;
                    end else begin
                        dz_d    = 1'b0;
                        acc_d   = {32'd0, op[1] ? in_a_mag : in_b_mag};
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (op_q[1]) begin
                        rem_d = rem_ge ? rem_sub : rem_shift[31:0];
                        acc_d = {32'd0, acc_q[30:0], rem_ge};
                    end else begin
                        acc_d = {mul_sum, acc_q[31:1]};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!flush) begin
                    hi_d = result[63:32];
                    lo_d = result[31:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 2'd0;
            a_mag_q <= 32'd0;
            b_mag_q <= 32'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            rem_q   <= 32'd0;
            acc_q   <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dz_q    <= dz_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // stall is gated by rst so a held start cannot raise it during reset.
    assign stall     = !rst && (((state_q == IDLE) && start && !flush) || (state_q == RUN));
    assign res_valid = (state_q == DONE);
    assign res       = (state_q == DONE) ? result : 64'd0;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed results, latency/stall timing, flush, reset and HI/LO writes.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        flush;
    logic        we_hi, we_lo;
    logic [31:0] wdata;
    logic        stall, res_valid;
    logic [63:0] res;
    logic [31:0] hi, lo;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    muldiv_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .we_hi    (we_hi),
        .we_lo    (we_lo),
        .wdata    (wdata),
        .stall    (stall),
        .res_valid(res_valid),
        .res      (res),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation at a negedge and follow it to the committed HI/LO.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_lat,
                          input logic wlo_in_done);
        int lat = 0;
        int stalls;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        #1;
        check({tag, "_stall_start"}, 64'(stall), 64'd1);
        stalls = 1;
        forever begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (res_valid) break;
            if (stall) stalls++;
            if (lat > 40) break;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_stall_count"}, 64'(stalls), 64'(exp_lat));
        check({tag, "_stall_done"}, 64'(stall), 64'd0);
        check({tag, "_res"}, res, {exp_hi, exp_lo});
        if (wlo_in_done) begin
            we_lo = 1'b1; wdata = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        we_lo = 1'b0;
        check({tag, "_valid_drop"}, 64'(res_valid), 64'd0);
        check({tag, "_res_zero"}, res, 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        @(negedge clk); we_hi = 1'b1; wdata = h;
        @(negedge clk); we_hi = 1'b0; we_lo = 1'b1; wdata = l;
        @(negedge clk); we_lo = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = MULT; a = '0; b = '0;
        flush = 1'b0; we_hi = 1'b0; we_lo = 1'b0; wdata = '0;
        #12;
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_res", res, 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        @(negedge clk); rst = 1'b0;

        run_op("div_7_m2",     DIV,   32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, 1'b0);
        run_op("divu_big",     DIVU,  32'hFFFF_FFFF,  32'h10,        32'h0000_000F, 32'h0FFF_FFFF, 33, 1'b0);
        run_op("multu_max",    MULTU, 32'hFFFF_FFFF,  32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 33, 1'b0);
        run_op("mult_m1_m1",   MULT,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 33, 1'b0);
        run_op("mult_min_min", MULT,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33, 1'b0);
        run_op("mult_m3_5",    MULT,  32'hFFFF_FFFD,  32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, 1'b0);
        run_op("div_min_m1",   DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 1'b0);
        run_op("div_m7_2",     DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0);
        run_op("divu_100_7",   DIVU,  32'd100,        32'd7,         32'd2,         32'd14,        33, 1'b0);
        run_op("div_5_0",      DIV,   32'd5,          32'd0,         32'd5,         32'hFFFF_FFFF, 1,  1'b0);
        run_op("divu_m5_0",    DIVU,  32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1,  1'b0);

        // Flush beats start in IDLE: a divide-by-zero request would otherwise be valid next cycle.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = DIV; a = 32'd9; b = 32'd0;
        #1;
        check("flush_idle_stall", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_idle_valid", 64'(res_valid), 64'd0);

        // Flush mid-RUN at cnt=10 leaves preloaded HI/LO untouched.
        write_hilo(32'h1111_1111, 32'h2222_2222);
        check("preload_hi", 64'(hi), 64'h1111_1111);
        check("preload_lo", 64'(lo), 64'h2222_2222);
        @(negedge clk);
        start = 1'b1; op = MULTU; a = 32'd3; b = 32'd4;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_run_stall", 64'(stall), 64'd0);
        check("flush_run_valid", 64'(res_valid), 64'd0);
        repeat (35) @(negedge clk);
        check("flush_run_hi", 64'(hi), 64'h1111_1111);
        check("flush_run_lo", 64'(lo), 64'h2222_2222);
        run_op("after_flush", MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 33, 1'b0);

        // Reset pulse at cnt=20 clears everything immediately.
        write_hilo(32'h3333_3333, 32'h4444_4444);
        @(negedge clk);
        start = 1'b1; op = DIVU; a = 32'd1000; b = 32'd3;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("midrst_stall", 64'(stall), 64'd0);
        check("midrst_valid", 64'(res_valid), 64'd0);
        check("midrst_res", res, 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, 33, 1'b0);

        // we_lo in the DONE cycle loses to the result commit.
        run_op("we_lo_done", MULT, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 33, 1'b1);

        // we_hi in IDLE still writes.
        @(negedge clk); we_hi = 1'b1; wdata = 32'hCAFE_F00D;
        @(negedge clk); we_hi = 1'b0;
        check("we_hi_idle", 64'(hi), 64'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
